switch_debounce: RTL and testbench

Debounces a bank of raw, bouncy switch inputs into a clean registered bus that feeds the 4-bit inverter stage's `a` input directly. Each bit is filtered independently: an output bit changes only after its input has held the new level for `CNT_MAX` consecutive clock edges. One-cycle edge and change strobes are provided so downstream logic can react to transitions without re-deriving them.

---
 rtl/switch_debounce_pkg.sv | 12 +
 rtl/debounce_bit.sv | 87 ++++++++
 rtl/switch_debounce.sv | 47 ++++
 tb/tb_switch_debounce.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared types and default sizing for the switch debouncer.
package switch_debounce_pkg;

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_COUNTING = 1'b1
    } deb_state_t;

    localparam int DEB_WIDTH   = 4;
    localparam int DEB_CNT_MAX = 15;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debounce filter: optional 2-flop synchronizer (SWITCH_DEBOUNCE_SYNC_EN),
// saturating run counter, two-state FSM and registered edge pulses.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int CNT_MAX = DEB_CNT_MAX,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic y_o,
    output logic rise_o,
    output logic fall_o,
    output logic pulse_d_o
);

    logic s;

`ifdef SWITCH_DEBOUNCE_SYNC_EN
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], sw_i};

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign s = sync_q[1];
`else
    assign s = sw_i;
`endif

    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             differ, accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DEB_STABLE;
            cnt_q   <= '0;
            y_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A run of CNT_MAX differing samples is accepted on its last sample, so
    // the counter tops out at CNT_MAX-1 and never wraps.
    always_comb begin
        differ  = (s != y_q);
        accept  = differ && (cnt_q == CNT_W'(CNT_MAX - 1));
        state_d = DEB_STABLE;
        cnt_d   = '0;
        if (differ && !accept) begin
            state_d = DEB_COUNTING;
            cnt_d   = (state_q == DEB_COUNTING) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        end
    end

    always_comb begin
        y_d    = y_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (accept) begin
            y_d    = s;
            rise_d = s;
            fall_d = ~s;
        end
    end

    assign y_o       = y_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign pulse_d_o = rise_d | fall_d;

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch bank: WIDTH independent filters plus a registered any-change strobe.
// Define SWITCH_DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of each filter.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH   = DEB_WIDTH,
    parameter int CNT_MAX = DEB_CNT_MAX,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] pulse_d;
    logic             changed_q, changed_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX),
            .CNT_W   (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_i      (sw[g]),
            .y_o       (y[g]),
            .rise_o    (rise[g]),
            .fall_o    (fall[g]),
            .pulse_d_o (pulse_d[g])
        );
    end

    // Built from next-cycle pulses so it lines up with rise/fall.
    always_comb changed_d = |pulse_d;

    always_ff @(posedge clk) begin
        if (reset) changed_q <= 1'b0;
        else       changed_q <= changed_d;
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce (CNT_MAX=4) with a sliding-window reference model.
module tb_switch_debounce;

    localparam int WIDTH   = 4;
    localparam int CNT_MAX = 4;
`ifdef SWITCH_DEBOUNCE_SYNC_EN
    localparam int LAT = CNT_MAX + 2;
`else
    localparam int LAT = CNT_MAX;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] y, rise, fall;
    logic             changed;

    int n_assert = 0;
    int n_fail   = 0;

    switch_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .y       (y),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: a bit flips once its last CNT_MAX filter samples all differ from it.
    logic [WIDTH-1:0] m_y, m_rise, m_fall;
    logic             m_chg;
    logic [WIDTH-1:0] hist[$];
`ifdef SWITCH_DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] dly[$];
`endif
    bit m_ok = 0;

    always @(posedge clk) begin
        logic [WIDTH-1:0] s, nr, nf;
        bit all_diff;
        m_ok = 1;
        if (reset) begin
            m_y = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            hist.delete();
`ifdef SWITCH_DEBOUNCE_SYNC_EN
            dly = '{'0, '0};
`endif
        end else begin
`ifdef SWITCH_DEBOUNCE_SYNC_EN
            dly.push_back(sw);
            s = dly.pop_front();
`else
            s = sw;
`endif
            hist.push_back(s);
            if (hist.size() > CNT_MAX) void'(hist.pop_front());
            nr = '0; nf = '0;
            if (hist.size() == CNT_MAX) begin
                for (int i = 0; i < WIDTH; i++) begin
                    all_diff = 1;
                    foreach (hist[k]) if (hist[k][i] == m_y[i]) all_diff = 0;
                    if (all_diff) begin
                        if (m_y[i]) nf[i] = 1'b1;
                        else        nr[i] = 1'b1;
                    end
                end
            end
            m_y    = m_y ^ (nr | nf);
            m_rise = nr;
            m_fall = nf;
            m_chg  = |(nr | nf);
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_y",       32'(y),       32'(m_y));
            chk("model_rise",    32'(rise),    32'(m_rise));
            chk("model_fall",    32'(fall),    32'(m_fall));
            chk("model_changed", 32'(changed), 32'(m_chg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        sw    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc(20);
        chk("idle_y", 32'(y), 32'h0);
        chk("idle_pulses", 32'({rise, fall, changed}), 32'h0);

        // 3-edge glitch on bit 0 must be discarded
        sw = 4'h1; cyc(3);
        sw = 4'h0; cyc(10);
        chk("glitch_y", 32'(y), 32'h0);

        sw = 4'h1; cyc(LAT - 1);
        chk("hold0_pre_y", 32'(y), 32'h0);
        cyc(1);
        chk("hold0_y", 32'(y), 32'h1);
        chk("hold0_rise", 32'(rise), 32'h1);
        chk("hold0_chg", 32'(changed), 32'h1);
        cyc(1);
        chk("hold0_rise_off", 32'(rise), 32'h0);
        chk("hold0_chg_off", 32'(changed), 32'h0);

        sw = 4'h5; cyc(LAT);
        chk("to5_y", 32'(y), 32'h5);
        chk("to5_rise", 32'(rise), 32'h4);
        cyc(1);

        sw = 4'h4; cyc(LAT);
        chk("to4_y", 32'(y), 32'h4);
        chk("to4_fall", 32'(fall), 32'h1);
        chk("to4_rise", 32'(rise), 32'h0);
        cyc(3);

        // simultaneous rise on bit 1 and fall on bit 2
        sw = 4'h2; cyc(LAT - 1);
        chk("sim_pre_y", 32'(y), 32'h4);
        cyc(1);
        chk("sim_y", 32'(y), 32'h2);
        chk("sim_rise", 32'(rise), 32'h2);
        chk("sim_fall", 32'(fall), 32'h4);
        chk("sim_chg", 32'(changed), 32'h1);
        cyc(1);
        chk("sim_chg_off", 32'(changed), 32'h0);

        // reset in the middle of a count drops the partial run
        sw = 4'hF; cyc(3);
        reset = 1'b1; cyc(1);
        reset = 1'b0;
        chk("rst_y", 32'(y), 32'h0);
        cyc(LAT - 1);
        chk("rst_pre_y", 32'(y), 32'h0);
        cyc(1);
        chk("rst_y_F", 32'(y), 32'hF);
        chk("rst_rise", 32'(rise), 32'hF);

        // long hold: counter must not wrap into a spurious change
        cyc(40);
        chk("hold_y", 32'(y), 32'hF);
        chk("hold_chg", 32'(changed), 32'h0);

        sw = 4'h8; cyc(LAT - 1);
        chk("to8_pre_y", 32'(y), 32'hF);
        cyc(1);
        chk("to8_y", 32'(y), 32'h8);
        chk("to8_fall", 32'(fall), 32'h7);
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
